// File: rtl/matrix_mem_initiator_if.sv
// Controller handshake plus main-memory bus bundle for the matrix initiator.
// No latency of its own; pure wiring between controller, initiator and memory.
// No backpressure: the controller waits on Done, memory answers every strobe.
interface matrix_mem_initiator_if;
    // controller -> initiator request
    logic         Start;
    logic [1:0]   Op;
    logic [15:0]  SrcAddrA;
    logic [15:0]  SrcAddrB;
    logic [15:0]  DstAddr;
    // initiator -> controller status
    logic         Busy;
    logic         Done;
    logic         Error;
    logic [255:0] Result;
    // initiator <-> memory bus
    logic [15:0]  Address;
    logic         nRead;
    logic         nWrite;
    logic [255:0] MemWrData;
    logic [255:0] MemRdData;

    // Initiator side: takes requests and read data, drives the bus and status.
    modport master (
        input  Start, Op, SrcAddrA, SrcAddrB, DstAddr, MemRdData,
        output Busy, Done, Error, Result, Address, nRead, nWrite, MemWrData
    );

    // Environment side: controller and memory seen as one peer.
    modport slave (
        output Start, Op, SrcAddrA, SrcAddrB, DstAddr, MemRdData,
        input  Busy, Done, Error, Result, Address, nRead, nWrite, MemWrData
    );
endinterface

// File: rtl/matrix_mem_initiator.sv
// Reads two 256-bit operands, combines them in 16 independent 16-bit lanes, writes one result.
// Start accepted at edge 0 -> Done in cycle 5 (cycle 1 for a rejected request).
// No backpressure: Start is only sampled in IDLE; pulses while Busy are dropped, not queued.
module matrix_mem_initiator #(
    parameter logic [3:0] MODULE_ID = 4'h0,
    parameter int         MEM_DEPTH = 12,
    parameter bit         SATURATE  = 1'b0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    matrix_mem_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    state_t         state_q, state_d;

    // Request fields latched when Start is accepted. The A address is only
    // needed in the acceptance cycle itself (it is driven straight into RD_A),
    // so it is taken from the request port rather than from a latch.
    logic [1:0]     op_q;
    logic [15:0]    src_b_q;
    logic [15:0]    dst_q;

    logic [255:0]   reg_a_q;
    logic [255:0]   result_q;
    logic [255:0]   wr_data_q;
    logic           error_q;

    // Bus/status outputs are registered; their next values are decoded from
    // the next state so each strobe lines up exactly with its state's cycle.
    logic [15:0]    addr_q, addr_d;
    logic           nread_q, nread_d;
    logic           nwrite_q, nwrite_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           req_ok;
    logic           start_acc;
    logic [255:0]   lane_res;

    // A location is reachable only with the right module select and an in-range index.
    function automatic logic addr_ok(input logic [15:0] a);
        return (a[15:12] == MODULE_ID) && (int'({20'd0, a[11:0]}) < MEM_DEPTH);
    endfunction

    assign req_ok    = addr_ok(bus.SrcAddrA) && addr_ok(bus.SrcAddrB) &&
                       addr_ok(bus.DstAddr) && (bus.Op != OP_ILL);
    assign start_acc = (state_q == IDLE) && bus.Start;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed walk through the bus phases; rejects skip to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = req_ok ? RD_A : DONE;
                end
            end
            RD_A:    state_d = RD_B;
            RD_B:    state_d = CAP_B;
            CAP_B:   state_d = WR;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state being entered; Address holds outside the strobe phases.
    always_comb begin
        addr_d   = addr_q;
        nread_d  = 1'b1;
        nwrite_d = 1'b1;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        case (state_d)
            RD_A: begin
                // Only reachable from IDLE, so the request port still holds A.
                addr_d  = bus.SrcAddrA;
                nread_d = 1'b0;
            end
            RD_B: begin
                addr_d  = src_b_q;
                nread_d = 1'b0;
            end
            WR: begin
                addr_d   = dst_q;
                nwrite_d = 1'b0;
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // Registered bus strobes and status; reset forces strobes inactive at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q   <= 16'h0000;
            nread_q  <= 1'b1;
            nwrite_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            nread_q  <= nread_d;
            nwrite_q <= nwrite_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Lane-wise arithmetic on RegA and operand B as it sits on the read bus in CAP_B.
    // Each lane is widened by one bit so the carry/borrow out drives the clamp.
    always_comb begin
        lane_res = '0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] la;
            logic [15:0] lb;
            logic [16:0] sum;
            logic [16:0] dif;
            la  = reg_a_q[16*i +: 16];
            lb  = bus.MemRdData[16*i +: 16];
            sum = {1'b0, la} + {1'b0, lb};
            dif = {1'b0, la} - {1'b0, lb};
            case (op_q)
                OP_ADD:  lane_res[16*i +: 16] = (SATURATE && sum[16]) ? 16'hFFFF : sum[15:0];
                OP_SUB:  lane_res[16*i +: 16] = (SATURATE && dif[16]) ? 16'h0000 : dif[15:0];
                OP_COPY: lane_res[16*i +: 16] = la;
                default: lane_res[16*i +: 16] = la;
            endcase
        end
    end

    // Request latch and error flag; Error clears on every accepted Start and holds otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q    <= OP_ADD;
            src_b_q <= 16'h0000;
            dst_q   <= 16'h0000;
            error_q <= 1'b0;
        end else if (start_acc) begin
            op_q    <= bus.Op;
            src_b_q <= bus.SrcAddrB;
            dst_q   <= bus.DstAddr;
            error_q <= ~req_ok;
        end
    end

    // Operand A captured at the end of RD_B, when its registered read data is valid.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            reg_a_q <= '0;
        end else if (state_q == RD_B) begin
            reg_a_q <= bus.MemRdData;
        end
    end

    // Result and write data loaded together at the end of CAP_B; both hold afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result_q  <= '0;
            wr_data_q <= '0;
        end else if (state_q == CAP_B) begin
            result_q  <= lane_res;
            wr_data_q <= lane_res;
        end
    end

    assign bus.Address   = addr_q;
    assign bus.nRead     = nread_q;
    assign bus.nWrite    = nwrite_q;
    assign bus.MemWrData = wr_data_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
    assign bus.Result    = result_q;

endmodule

// File: doc/matrix_mem_initiator.md
Name: matrix_mem_initiator

Overview:
- Bus initiator for the main-memory block: issues reads of two 256-bit matrix operands, combines them lane-wise, and writes one 256-bit result back.
- Drives the memory's 16-bit address, active-low nRead/nWrite and 256-bit write data; consumes the memory's registered 256-bit read data.
- Sits between the top-level controller (Start/Done handshake) and main memory.

Parameters:
- MODULE_ID, 4'h0, value required in address[15:12] to select main memory.
- MEM_DEPTH, 12, number of valid 256-bit locations; address[11:0] must be < MEM_DEPTH.
- SATURATE, 0, 0 = lane arithmetic wraps mod 2^16; 1 = unsigned saturating (clamp 0xFFFF / 0x0000).

Ports:
- Clk  input  1  single clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request pulse, sampled in IDLE only.
- Op  input  2  00 add A+B, 01 subtract A-B, 10 copy A, 11 illegal.
- SrcAddrA, SrcAddrB, DstAddr  input  16 each  full bus addresses (module select + location).
- Address  output  16  bus address to memory.
- nRead  output  1  active-low read strobe.
- nWrite  output  1  active-low write strobe.
- MemWrData  output  256  write data, to memory DataIn.
- MemRdData  input  256  read data, from memory DataOut.
- Busy  output  1  high from the cycle after Start is accepted until DONE exits.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  valid with Done; held until the next Start is accepted.
- Result  output  256  last computed value; held between operations.

Behaviour:
- Interface: one clock Clk; reset Reset, asynchronous and active-high.
- Reset values (apply immediately on Reset assertion, including mid-operation):
  - Address=0, nRead=1, nWrite=1, MemWrData=0, Busy=0, Done=0, Error=0, Result=0, state=IDLE.
  - No partial write is ever issued after reset.
- Memory timing: read data is registered. With nRead=0 during cycle N, MemRdData is valid throughout cycle N+1. Writes commit at the posedge that ends the nWrite=0 cycle.
- FSM states: IDLE, RD_A, RD_B, CAP_B, WR, DONE.
- IDLE:
  - On Start=1, latch Op and all three addresses and clear Error.
  - Validate every address: [15:12]==MODULE_ID and [11:0]<MEM_DEPTH. Op==11 is also invalid.
  - Valid request: go to RD_A. Invalid request: go directly to DONE with Error=1 and no bus strobe ever asserted.
- RD_A: Address=SrcAddrA, nRead=0 for exactly one cycle.
- RD_B:
  - Address=SrcAddrB, nRead=0.
  - MemRdData (operand A) is captured into RegA at the posedge that ends RD_B.
- CAP_B:
  - nRead=1; MemRdData holds operand B.
  - At the posedge ending this state, Result is computed from RegA and MemRdData and also loaded into MemWrData.
- WR: Address=DstAddr, nWrite=0, MemWrData stable, for exactly one cycle.
- DONE: nWrite=1, Done=1 for one cycle, then return to IDLE.
- Latency: Start sampled at edge 0 gives RD_A in cycle 1 and Done=1 in cycle 5. An error request gives Done in cycle 1.
- Strobe rules:
  - nRead and nWrite are never low in the same cycle.
  - Outside RD_A/RD_B/WR, both strobes are high and Address holds its last value.
- Arithmetic: 16 independent lanes; lane i = bits [16i+15:16i]; no carries or borrows between lanes.
  - Add: wraps, or clamps to 0xFFFF if SATURATE=1.
  - Subtract: wraps, or clamps to 0x0000 if SATURATE=1.
  - Copy: Result=RegA; B is still read, and its value is ignored.
- Start while Busy is ignored; no queuing.
- Same source and destination addresses are legal; reads complete before the write.
- Done and Busy are never both asserted in IDLE.

Test Plan:
- Reset with memory loc0 = 256'h0001_0002_…_0010 and loc1 = 256'h0020_001f_…_0011. Then Start, Op=00, A=0x0000, B=0x0001, Dst=0x0002 -> strobes in cycles 1/2/4, Done in cycle 5, loc2 = 0x0021 in all 16 lanes, Error=0.
- Same operands with Op=01 and SATURATE=0 -> lane0=0xFFFF, lane15=0xFFE1. Repeat with SATURATE=1 -> every lane 0x0000.
- Op=10, A=0x0001, Dst=0x0001 -> loc1 unchanged, Result equals loc1 contents, nRead asserted twice, nWrite once.
- Invalid requests: DstAddr=0x1002, then SrcAddrA=0x000C, then Op=11 -> each gives Done one cycle after Start with Error=1, nRead/nWrite never low, memory unchanged.
- Reset asserted asynchronously during CAP_B -> outputs return to reset values in the same cycle without waiting for Clk, destination location not written. A later Start completes normally.
- Start pulsed repeatedly while Busy -> exactly one operation and one Done pulse. A back-to-back Start in the cycle after Done is accepted.
